// File: rtl/camera_power_seq.sv
// ---------------------------------------------------------------------------
// camera_power_seq
//
// Power-up sequencer for NUM_CAM image sensors. It drives the common sensor
// power sequence: PWDN release, then RESETB release, then SCCB-init enable.
// It also provides:
//   - per-channel enable masking,
//   - a software restart path that power-cycles every sensor,
//   - a ready flag and a state readout.
//
// Ports
//   clk_50M      in   1        board 50 MHz clock
//   reset_n      in   1        synchronous, active-low reset
//   restart      in   1        request to power-cycle all sensors (pulse it)
//   cam_en       in   NUM_CAM  per-channel enable; 0 keeps that channel off
//   camera_pwnd  out  NUM_CAM  per-channel PWDN, active-high
//   camera_rstn  out  NUM_CAM  per-channel RESETB, active-low
//   initial_en   out  1        high once sensors may be configured over SCCB
//   ready        out  1        high in READY
//   seq_state    out  3        state: OFF=0 PWDN_WAIT=1 RST_WAIT=2
//                              INIT_WAIT=3 READY=4
//
// Build option
//   CAM_SEQ_SIM_FAST_EN : when defined, the delays shrink to
//                         T_PWDN=25, T_RST=5, T_INIT=105, T_OFF=10 cycles.
//                         This is for simulation only. CNT_W is not changed.
// ---------------------------------------------------------------------------
module camera_power_seq #(
   parameter int NUM_CAM = 2,
   parameter int T_PWDN  = 250000,
   parameter int T_RST   = 65000,
   parameter int T_INIT  = 1050000,
   parameter int T_OFF   = 50000,
   parameter int CNT_W   = 21
) (
   input  logic               clk_50M,
   input  logic               reset_n,
   input  logic               restart,
   input  logic [NUM_CAM-1:0] cam_en,
   output logic [NUM_CAM-1:0] camera_pwnd,
   output logic [NUM_CAM-1:0] camera_rstn,
   output logic               initial_en,
   output logic               ready,
   output logic [2:0]         seq_state
);

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_PWDN_WAIT = 3'd1,
      ST_RST_WAIT  = 3'd2,
      ST_INIT_WAIT = 3'd3,
      ST_READY     = 3'd4
   } state_t;

`ifdef CAM_SEQ_SIM_FAST_EN
   localparam int D_PWDN = 25;
   localparam int D_RST  = 5;
   localparam int D_INIT = 105;
   localparam int D_OFF  = 10;
`else
   localparam int D_PWDN = T_PWDN;
   localparam int D_RST  = T_RST;
   localparam int D_INIT = T_INIT;
   localparam int D_OFF  = T_OFF;
`endif

   // Terminal count for each timed state. A state entered with cnt=0
   // therefore lasts exactly D_* cycles.
   localparam logic [CNT_W-1:0] LAST_PWDN = CNT_W'(D_PWDN - 1);
   localparam logic [CNT_W-1:0] LAST_RST  = CNT_W'(D_RST  - 1);
   localparam logic [CNT_W-1:0] LAST_INIT = CNT_W'(D_INIT - 1);
   localparam logic [CNT_W-1:0] LAST_OFF  = CNT_W'(D_OFF  - 1);

   state_t             state_q,       state_d;
   logic [CNT_W-1:0]   cnt_q,         cnt_d;
   logic               restart_prev_q, restart_prev_d;
   logic [NUM_CAM-1:0] camera_pwnd_q, camera_pwnd_d;
   logic [NUM_CAM-1:0] camera_rstn_q, camera_rstn_d;
   logic               initial_en_q,  initial_en_d;
   logic               ready_q,       ready_d;
   logic [2:0]         seq_state_q,   seq_state_d;

   logic               restart_pulse;
   logic               seq_pwnd_d;
   logic               seq_rstn_d;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q + CNT_W'(1);
      restart_prev_d = restart;

      // A held-high restart acts only once. Without this, a long pulse
      // would re-enter OFF each time the sequence leaves OFF.
      restart_pulse  = restart & ~restart_prev_q;

      case (state_q)
         ST_OFF: begin
            if (cnt_q == LAST_OFF) begin
               cnt_d   = '0;
               state_d = ST_PWDN_WAIT;
            end
         end
         ST_PWDN_WAIT: begin
            if (cnt_q == LAST_PWDN) begin
               cnt_d   = '0;
               state_d = ST_RST_WAIT;
            end
         end
         ST_RST_WAIT: begin
            if (cnt_q == LAST_RST) begin
               cnt_d   = '0;
               state_d = ST_INIT_WAIT;
            end
         end
         ST_INIT_WAIT: begin
            if (cnt_q == LAST_INIT) begin
               cnt_d   = '0;
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            // Terminal state. Keep the counter parked at zero.
            cnt_d = '0;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_PWDN_WAIT;
         end
      endcase

      // A restart seen while already OFF is dropped, so it cannot
      // stretch the off time.
      if (restart_pulse && (state_q != ST_OFF)) begin
         state_d = ST_OFF;
         cnt_d   = '0;
      end

      // The outputs are decoded from the next state. This lets the
      // registered outputs change on the same edge as the state.
      seq_pwnd_d    = (state_d == ST_OFF) || (state_d == ST_PWDN_WAIT);
      seq_rstn_d    = (state_d == ST_INIT_WAIT) || (state_d == ST_READY);

      camera_pwnd_d = {NUM_CAM{seq_pwnd_d}} | ~cam_en;
      camera_rstn_d = {NUM_CAM{seq_rstn_d}} &  cam_en;
      initial_en_d  = (state_d == ST_READY);
      ready_d       = (state_d == ST_READY);
      seq_state_d   = state_d;
   end

   // Reset enters PWDN_WAIT directly. Power-on does not pass through OFF.
   always_ff @(posedge clk_50M) begin
      if (!reset_n) begin
         state_q        <= ST_PWDN_WAIT;
         cnt_q          <= '0;
         restart_prev_q <= 1'b0;
         camera_pwnd_q  <= '1;
         camera_rstn_q  <= '0;
         initial_en_q   <= 1'b0;
         ready_q        <= 1'b0;
         seq_state_q    <= 3'd1;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         restart_prev_q <= restart_prev_d;
         camera_pwnd_q  <= camera_pwnd_d;
         camera_rstn_q  <= camera_rstn_d;
         initial_en_q   <= initial_en_d;
         ready_q        <= ready_d;
         seq_state_q    <= seq_state_d;
      end
   end

   assign camera_pwnd = camera_pwnd_q;
   assign camera_rstn = camera_rstn_q;
   assign initial_en  = initial_en_q;
   assign ready       = ready_q;
   assign seq_state   = seq_state_q;

endmodule

// File: tb/tb_camera_power_seq.sv
// ---------------------------------------------------------------------------
// Testbench for camera_power_seq (NUM_CAM=2). The DUT gets the short delays
// 25/5/105/10 through its parameters, so the timing does not depend on
// whether CAM_SEQ_SIM_FAST_EN is defined.
//
// The reference model works on a timeline. It remembers the edge at which
// the current sequence started and whether that sequence begins with an off
// period. The expected state comes from the elapsed cycle count.
// Edge numbering: an input driven just after edge X is first sampled at
// edge X+1. The output value "at edge Y" is the value just after edge Y.
// ---------------------------------------------------------------------------
module tb_camera_power_seq;

   localparam int NC     = 2;
   localparam int TP     = 25;
   localparam int TR     = 5;
   localparam int TI     = 105;
   localparam int TO     = 10;
   localparam int T_FULL = TP + TR + TI;

   logic          clk_50M = 1'b0;
   logic          reset_n = 1'b0;
   logic          restart = 1'b0;
   logic [NC-1:0] cam_en  = 2'b11;
   logic [NC-1:0] camera_pwnd;
   logic [NC-1:0] camera_rstn;
   logic          initial_en;
   logic          ready;
   logic [2:0]    seq_state;

   camera_power_seq #(
      .NUM_CAM (NC),
      .T_PWDN  (TP),
      .T_RST   (TR),
      .T_INIT  (TI),
      .T_OFF   (TO),
      .CNT_W   (21)
   ) dut (
      .clk_50M     (clk_50M),
      .reset_n     (reset_n),
      .restart     (restart),
      .cam_en      (cam_en),
      .camera_pwnd (camera_pwnd),
      .camera_rstn (camera_rstn),
      .initial_en  (initial_en),
      .ready       (ready),
      .seq_state   (seq_state)
   );

   always #10 clk_50M = ~clk_50M;

   int n_total = 0;
   int n_pass  = 0;

   // Reference timeline
   int n         = -1;   // index of the last completed edge
   int seq_start = 0;
   int with_off  = 0;
   int rs_prev   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, obs, exp);
      else
         n_pass++;
   endtask

   // Expected state just after edge k: 0=OFF 1=PWDN 2=RST 3=INIT 4=READY
   function automatic int model_state(input int k);
      int e;
      int offs;
      e    = k - seq_start;
      offs = with_off ? TO : 0;
      if (e < offs)                return 0;
      else if (e < offs + TP)      return 1;
      else if (e < offs + TP + TR) return 2;
      else if (e < offs + T_FULL)  return 3;
      else                         return 4;
   endfunction

   task automatic step();
      logic          s_rst;
      logic          s_rs;
      logic [NC-1:0] s_ce;
      int            prior;
      int            st;
      logic [NC-1:0] e_pwnd;
      logic [NC-1:0] e_rstn;
      @(posedge clk_50M);
      s_rst = reset_n;
      s_rs  = restart;
      s_ce  = cam_en;
      prior = model_state(n);
      n++;
      if (!s_rst) begin
         seq_start = n;
         with_off  = 0;
         rs_prev   = 0;
      end else begin
         if (s_rs && !rs_prev && prior != 0) begin
            seq_start = n;
            with_off  = 1;
         end
         rs_prev = s_rs;
      end
      st     = model_state(n);
      e_pwnd = (st <= 1) ? 2'b11 : ~s_ce;
      e_rstn = (st >= 3) ? s_ce  : 2'b00;
      #1;
      chk("pwnd",  32'(camera_pwnd), 32'(e_pwnd));
      chk("rstn",  32'(camera_rstn), 32'(e_rstn));
      chk("ien",   32'(initial_en),  32'(st == 4));
      chk("ready", 32'(ready),       32'(st == 4));
      chk("state", 32'(seq_state),   32'(st));
   endtask

   task automatic run_to(input int target);
      while (n < target) step();
   endtask

   task automatic do_reset(input int cycles);
      reset_n = 1'b0;
      repeat (cycles) step();
      reset_n = 1'b1;
   endtask

   int base;
   int r;

   initial begin
      // Nominal power-up
      cam_en = 2'b11;
      do_reset(10);
      chk("rst_pwnd", 32'(camera_pwnd), 32'h3);
      chk("rst_rstn", 32'(camera_rstn), 32'h0);
      base = n;
      run_to(base + 24);  chk("pwnd@24",  32'(camera_pwnd), 32'h3);
      run_to(base + 25);  chk("pwnd@25",  32'(camera_pwnd), 32'h0);
      run_to(base + 29);  chk("rstn@29",  32'(camera_rstn), 32'h0);
      run_to(base + 30);  chk("rstn@30",  32'(camera_rstn), 32'h3);
      run_to(base + 134); chk("ien@134",  32'(initial_en),  32'h0);
      run_to(base + 135); chk("ien@135",  32'(initial_en),  32'h1);
      chk("state@135", 32'(seq_state), 32'h4);
      run_to(base + 140);

      // Restart from READY
      r = n;
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("rs_ien@R+1",  32'(initial_en),  32'h0);
      chk("rs_pwnd@R+1", 32'(camera_pwnd), 32'h3);
      chk("rs_rstn@R+1", 32'(camera_rstn), 32'h0);
      run_to(r + 35);  chk("rs_pwnd@R+35", 32'(camera_pwnd), 32'h3);
      run_to(r + 36);  chk("rs_pwnd@R+36", 32'(camera_pwnd), 32'h0);
      run_to(r + 145); chk("rs_ien@R+145", 32'(initial_en),  32'h0);
      run_to(r + 146); chk("rs_ien@R+146", 32'(initial_en),  32'h1);
      run_to(r + 150);

      // A second restart while OFF is ignored
      r = n;
      restart = 1'b1; step(); restart = 1'b0;
      step(); step();
      restart = 1'b1; step(); restart = 1'b0;
      run_to(r + 36);  chk("off2_pwnd@R+36", 32'(camera_pwnd), 32'h0);
      run_to(r + 145); chk("off2_ien@R+145", 32'(initial_en),  32'h0);
      run_to(r + 146); chk("off2_ien@R+146", 32'(initial_en),  32'h1);

      // Channel 1 masked for the whole sequence
      cam_en = 2'b01;
      do_reset(10);
      base = n;
      run_to(base + 25);  chk("mask_pwnd@25",  32'(camera_pwnd), 32'h2);
      run_to(base + 30);  chk("mask_rstn@30",  32'(camera_rstn), 32'h1);
      run_to(base + 135); chk("mask_ien@135",  32'(initial_en),  32'h1);
      chk("mask_pwnd@135", 32'(camera_pwnd), 32'h2);
      chk("mask_rstn@135", 32'(camera_rstn), 32'h1);
      cam_en = 2'b11;
      run_to(base + 140);

      // Reset in the middle of RST_WAIT
      do_reset(3);
      base = n;
      run_to(base + 28);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid_state", 32'(seq_state),   32'h1);
      chk("mid_pwnd",  32'(camera_pwnd), 32'h3);
      chk("mid_cnt",   32'(dut.cnt_q),   32'h0);
      base = n;
      run_to(base + 25);  chk("mid_pwnd@25", 32'(camera_pwnd), 32'h0);
      run_to(base + 135); chk("mid_ien@135", 32'(initial_en),  32'h1);

      // Random traffic. Each cycle is checked against the timeline model.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) cam_en = 2'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            do_reset($urandom_range(1, 3));
         end else if ($urandom_range(0, 79) == 0) begin
            restart = 1'b1;
            repeat ($urandom_range(1, 4)) step();
            restart = 1'b0;
         end else begin
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
